// File: rtl/sap2_alu_if.sv
// Operand, control and status bundle between the SAP-2 controller and the ALU.
// The tri-stated W-bus result stays a plain port on the ALU itself.
interface sap2_alu_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] a_input;
   logic [WIDTH-1:0] b_input;
   logic [3:0]       OP;
   logic             L_U;
   logic             E_U;
   logic [3:0]       flags_output;
   logic             busy;

   modport master (
      output a_input, b_input, OP, L_U, E_U,
      input  flags_output, busy
   );

   modport slave (
      input  a_input, b_input, OP, L_U, E_U,
      output flags_output, busy
   );
endinterface

// File: rtl/sap2_alu.sv
// SAP-2 ALU: registered result and {V,S,Z,C} flags, multi-cycle shifts and
// rotates one bit per clock, result driven onto the W-bus under E_U.
module sap2_alu #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             CLR,
   sap2_alu_if.slave        alu,
   output logic [WIDTH-1:0] bus_output
);
   localparam int SHW = $clog2(WIDTH);

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_ADC = 4'd2,  OP_SBB = 4'd3,
      OP_AND = 4'd4,  OP_OR  = 4'd5,  OP_XOR = 4'd6,  OP_NOT = 4'd7,
      OP_INC = 4'd8,  OP_DEC = 4'd9,  OP_SHL = 4'd10, OP_SHR = 4'd11,
      OP_ROL = 4'd12, OP_ROR = 4'd13, OP_NP0 = 4'd14, OP_NP1 = 4'd15
   } op_t;

   typedef enum logic {IDLE, SHIFT} state_t;

   typedef struct packed {
      logic v;
      logic s;
      logic z;
      logic c;
   } flags_t;

   state_t           state;
   op_t              shift_op;
   logic [SHW-1:0]   count;
   logic [WIDTH-1:0] result;
   flags_t           flags;

   op_t              op;
   logic [SHW-1:0]   n;
   logic [WIDTH-1:0] b_eff;
   logic             cin;
   logic [WIDTH:0]   sum;
   logic             ovf;
   logic [WIDTH-1:0] logic_res;
   logic [WIDTH-1:0] step_r;
   logic             step_c;

   assign op = op_t'(alu.OP);
   assign n  = alu.b_input[SHW-1:0];

   // Subtraction and decrement reuse the adder through an inverted or all-ones B.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      b_eff = alu.b_input;
      cin   = 1'b0;
      case (op)
         OP_SUB:  begin b_eff = ~alu.b_input; cin = 1'b1;    end
         OP_ADC:  cin = flags.c;
         OP_SBB:  begin b_eff = ~alu.b_input; cin = flags.c; end
         OP_INC:  begin b_eff = '0;           cin = 1'b1;    end
         OP_DEC:  b_eff = '1;
         default: ;
      endcase
   end

   assign sum = {1'b0, alu.a_input} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
   // Same-sign operands giving an opposite-sign result: equals carry-in XOR carry-out of the MSB.
   assign ovf = (alu.a_input[WIDTH-1] == b_eff[WIDTH-1]) &&
                (sum[WIDTH-1] != alu.a_input[WIDTH-1]);

   always_comb begin
      logic_res = '0;
      case (op)
         OP_AND:  logic_res = alu.a_input & alu.b_input;
         OP_OR:   logic_res = alu.a_input | alu.b_input;
         OP_XOR:  logic_res = alu.a_input ^ alu.b_input;
         OP_NOT:  logic_res = ~alu.a_input;
         default: ;
      endcase
   end

   // One step of the latched shift; rotates run through C as a WIDTH+1 bit ring.
   always_comb begin
      step_r = result;
      step_c = flags.c;
      case (shift_op)
         OP_SHL:  begin step_c = result[WIDTH-1]; step_r = {result[WIDTH-2:0], 1'b0};    end
         OP_SHR:  begin step_c = result[0];       step_r = {1'b0, result[WIDTH-1:1]};    end
         OP_ROL:  begin step_c = result[WIDTH-1]; step_r = {result[WIDTH-2:0], flags.c}; end
         OP_ROR:  begin step_c = result[0];       step_r = {flags.c, result[WIDTH-1:1]}; end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; the reset is
   // synchronous and every register here is an individual flop, so all are cleared.
   always_ff @(posedge CLK) begin
      if (CLR) begin
         state    <= IDLE;
         shift_op <= OP_SHL;
         count    <= '0;
         result   <= '0;
         flags    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (alu.L_U) begin
                  case (op)
                     OP_ADD, OP_SUB, OP_ADC, OP_SBB: begin
                        result <= sum[WIDTH-1:0];
                        flags  <= '{v: ovf, s: sum[WIDTH-1],
                                    z: (sum[WIDTH-1:0] == '0), c: sum[WIDTH]};
                     end
                     OP_INC, OP_DEC: begin
                        result  <= sum[WIDTH-1:0];
                        flags.v <= ovf;
                        flags.s <= sum[WIDTH-1];
                        flags.z <= (sum[WIDTH-1:0] == '0);
                     end
                     OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                        result <= logic_res;
                        flags  <= '{v: 1'b0, s: logic_res[WIDTH-1],
                                    z: (logic_res == '0), c: 1'b0};
                     end
                     OP_SHL, OP_SHR, OP_ROL, OP_ROR: begin
                        result <= alu.a_input;
                        if (n != '0) begin
                           count    <= n;
                           shift_op <= op;
                           state    <= SHIFT;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            SHIFT: begin
               result  <= step_r;
               flags.c <= step_c;
               count   <= count - SHW'(1);
               if (count == SHW'(1)) begin
                  flags.v <= 1'b0;
                  flags.s <= step_r[WIDTH-1];
                  flags.z <= (step_r == '0);
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign alu.flags_output = flags;
   assign alu.busy         = (state == SHIFT);
   assign bus_output       = alu.E_U ? result : {WIDTH{1'bz}};
endmodule

// File: tb/tb_sap2_alu.sv
// Directed bench for sap2_alu: an 8-bit and a 16-bit instance on one clock,
// hand-computed results and {V,S,Z,C} flags checked #1 after each rising edge.
module tb_sap2_alu;
   logic clk = 1'b0;
   logic clr;
   always #5 clk = ~clk;

   sap2_alu_if #(.WIDTH(8))  a8 ();
   sap2_alu_if #(.WIDTH(16)) a16 ();
   wire [7:0]  bus8;
   wire [15:0] bus16;

   sap2_alu #(.WIDTH(8))  dut8  (.CLK(clk), .CLR(clr), .alu(a8),  .bus_output(bus8));
   sap2_alu #(.WIDTH(16)) dut16 (.CLK(clk), .CLR(clr), .alu(a16), .bus_output(bus16));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic exec8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      a8.OP = op; a8.a_input = a; a8.b_input = b; a8.L_U = 1'b1;
      step();
      a8.L_U = 1'b0;
   endtask

   task automatic exec16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      a16.OP = op; a16.a_input = a; a16.b_input = b; a16.L_U = 1'b1;
      step();
      a16.L_U = 1'b0;
   endtask

   initial begin
      clr = 1'b1;
      a8.OP = 4'd0;  a8.a_input = '0;  a8.b_input = '0;  a8.L_U = 1'b0;  a8.E_U = 1'b1;
      a16.OP = 4'd0; a16.a_input = '0; a16.b_input = '0; a16.L_U = 1'b0; a16.E_U = 1'b1;
      step();
      step();
      clr = 1'b0;

      chk("reset bus8", bus8, 8'h00);
      chk("reset flags8", a8.flags_output, 4'b0000);
      chk("reset busy8", a8.busy, 1'b0);
      chk("reset bus16", bus16, 16'h0000);

      // Flags are {V,S,Z,C}.
      exec8(4'd0, 8'd128, 8'd32);
      chk("add bus", bus8, 8'hA0);
      chk("add flags", a8.flags_output, 4'b0100);
      a8.E_U = 1'b0;
      #1;
      n_cmp++;
      // A two-state simulator resolves an undriven net to 0; either way the result must not show.
      assert ((bus8 === 8'bzzzzzzzz) || (bus8 === 8'h00)) else begin
         n_bad++;
         $error("FAIL bus released: observed 0x%0h expected Z", bus8);
      end
      a8.E_U = 1'b1;
      #1;
      chk("add bus kept", bus8, 8'hA0);

      exec8(4'd1, 8'd200, 8'd32);
      chk("sub1 bus", bus8, 8'hA8);
      chk("sub1 flags", a8.flags_output, 4'b0101);
      exec8(4'd1, 8'd5, 8'd7);
      chk("sub2 bus", bus8, 8'hFE);
      chk("sub2 flags", a8.flags_output, 4'b0100);
      exec8(4'd1, 8'h80, 8'h01);
      chk("sub3 bus", bus8, 8'h7F);
      chk("sub3 flags", a8.flags_output, 4'b1001);

      exec8(4'd0, 8'hFF, 8'h01);
      chk("add wrap bus", bus8, 8'h00);
      chk("add wrap flags", a8.flags_output, 4'b0011);
      exec8(4'd2, 8'h00, 8'h00);
      chk("adc bus", bus8, 8'h01);
      chk("adc flags", a8.flags_output, 4'b0000);

      // INC/DEC leave C alone, so set it first.
      exec8(4'd0, 8'hFF, 8'h01);
      exec8(4'd8, 8'h7F, 8'h00);
      chk("inc bus", bus8, 8'h80);
      chk("inc flags", a8.flags_output, 4'b1101);
      exec8(4'd9, 8'h00, 8'h00);
      chk("dec bus", bus8, 8'hFF);
      chk("dec flags", a8.flags_output, 4'b0101);
      exec8(4'd6, 8'hAA, 8'hAA);
      chk("xor bus", bus8, 8'h00);
      chk("xor flags", a8.flags_output, 4'b0010);
      exec8(4'd4, 8'hF0, 8'h3C);
      chk("and bus", bus8, 8'h30);
      chk("and flags", a8.flags_output, 4'b0000);
      exec8(4'd14, 8'h55, 8'h55);
      chk("nop bus", bus8, 8'h30);
      chk("nop flags", a8.flags_output, 4'b0000);
      chk("nop busy", a8.busy, 1'b0);

      // SHL 0x81 by 3, with an ADD request arriving mid-shift.
      exec8(4'd10, 8'h81, 8'd3);
      chk("shl load bus", bus8, 8'h81);
      chk("shl load busy", a8.busy, 1'b1);
      a8.OP = 4'd0; a8.a_input = 8'h01; a8.b_input = 8'h01;
      step();
      chk("shl s1 bus", bus8, 8'h02);
      chk("shl s1 flags", a8.flags_output, 4'b0001);
      chk("shl s1 busy", a8.busy, 1'b1);
      a8.L_U = 1'b1;
      step();
      a8.L_U = 1'b0;
      chk("shl s2 bus", bus8, 8'h04);
      chk("shl s2 busy", a8.busy, 1'b1);
      step();
      chk("shl s3 bus", bus8, 8'h08);
      chk("shl done flags", a8.flags_output, 4'b0000);
      chk("shl done busy", a8.busy, 1'b0);

      exec8(4'd0, 8'hFF, 8'h01);
      exec8(4'd13, 8'h01, 8'd1);
      chk("ror load bus", bus8, 8'h01);
      chk("ror load flags", a8.flags_output, 4'b0011);
      step();
      chk("ror bus", bus8, 8'h80);
      chk("ror flags", a8.flags_output, 4'b0101);
      chk("ror busy", a8.busy, 1'b0);

      // Shift by zero only loads A.
      exec8(4'd10, 8'h42, 8'd0);
      chk("shl0 bus", bus8, 8'h42);
      chk("shl0 flags", a8.flags_output, 4'b0101);
      chk("shl0 busy", a8.busy, 1'b0);

      // CLR lands on the second step of SHR by 5.
      exec8(4'd11, 8'hF0, 8'd5);
      step();
      chk("shr s1 bus", bus8, 8'h78);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("clr bus", bus8, 8'h00);
      chk("clr flags", a8.flags_output, 4'b0000);
      chk("clr busy", a8.busy, 1'b0);
      exec8(4'd0, 8'h7F, 8'h01);
      chk("post clr add bus", bus8, 8'h80);
      chk("post clr add flags", a8.flags_output, 4'b1100);

      exec16(4'd0, 16'hFFFF, 16'h0001);
      chk("w16 add bus", bus16, 16'h0000);
      chk("w16 add flags", a16.flags_output, 4'b0011);
      exec16(4'd10, 16'h0001, 16'd15);
      chk("w16 shl load busy", a16.busy, 1'b1);
      for (int i = 1; i < 15; i++) begin
         step();
         chk($sformatf("w16 shl busy step %0d", i), a16.busy, 1'b1);
      end
      step();
      chk("w16 shl bus", bus16, 16'h8000);
      chk("w16 shl flags", a16.flags_output, 4'b0100);
      chk("w16 shl busy", a16.busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
